// File: rtl/message_receiver.sv
// message_receiver: bit-serial MSB-first word receiver.
// A start pulse in IDLE begins a message. Each bit window is BIT_CYC clocks
// long and the line is sampled once per window, at phase BIT_CYC/2. After the
// last window closes the word is published on data_out with a one-cycle valid.
module message_receiver #(
    parameter int MSG_W   = 16,
    parameter int BIT_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    output logic [MSG_W-1:0] data_out,
    output logic             valid,
    output logic             busy
);

    localparam int PH_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int CNT_W = $clog2(MSG_W + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(BIT_CYC / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(MSG_W);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COUNT,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] bit_cnt;
    logic [MSG_W-1:0] shift;

    logic [PH_W-1:0]  phase_inc;
    logic [PH_W-1:0]  phase_nxt;
    logic [CNT_W-1:0] bit_inc;
    logic             win_end;
    logic [MSG_W-1:0] shifted;

    // Phase counter wraps at the end of each bit window.
    assign phase_inc = phase + PH_W'(1);
    assign win_end   = (phase == PH_LAST);
    assign phase_nxt = win_end ? '0 : phase_inc;
    assign bit_inc   = bit_cnt + CNT_W'(1);

    // A one-bit message has nothing to shift out of the way.
    generate
        if (MSG_W == 1) begin : g_shift_one
            assign shifted = sin;
        end else begin : g_shift_many
            assign shifted = {shift[MSG_W-2:0], sin};
        end
    endgenerate

    // Receiver FSM with registered outputs. The sample and the window close
    // can land on the same cycle (BIT_CYC == 2), so SAMPLE also checks for the
    // final window and publishes the freshly shifted word directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end
                end
                INIT: begin
                    phase   <= '0;
                    bit_cnt <= '0;
                    shift   <= '0;
                    state   <= COUNT;
                end
                COUNT: begin
                    phase <= phase_nxt;
                    if (win_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            state    <= DONE;
                            data_out <= shift;
                            valid    <= 1'b1;
                        end
                    end else if (phase_inc == PH_MID) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    shift   <= shifted;
                    bit_cnt <= bit_inc;
                    phase   <= phase_nxt;
                    if (win_end && bit_inc == BIT_LAST) begin
                        state    <= DONE;
                        data_out <= shifted;
                        valid    <= 1'b1;
                    end else begin
                        state <= COUNT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_message_receiver.sv
// Bench for message_receiver: directed messages with a scoreboard of
// expected words and the exact cycle their valid pulse must appear in.
module tb_message_receiver;

    localparam int W   = 16;
    localparam int BC  = 8;
    localparam int LAT = W * BC + 2;   // start cycle to valid cycle
    localparam int LAT2 = 1 * 2 + 2;   // same for the MSG_W=1, BIT_CYC=2 instance

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sin = 1'b0;
    logic [W-1:0]  data_out;
    logic          valid;
    logic          busy;
    logic          start2 = 1'b0;
    logic          sin2 = 1'b0;
    logic [0:0]    data2;
    logic          valid2;
    logic          busy2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];

    message_receiver #(.MSG_W(W), .BIT_CYC(BC)) dut (
        .clk(clk), .rst(rst), .start(start), .sin(sin),
        .data_out(data_out), .valid(valid), .busy(busy)
    );

    message_receiver #(.MSG_W(1), .BIT_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sin(sin2),
        .data_out(data2), .valid(valid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    // Monitor for the default instance: pops on valid, checks word, cycle,
    // single-cycle pulse, busy drop, and that data_out holds between pulses.
    logic [W-1:0] prev_data = '0;
    bit           busy_pend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_data = data_out;
            busy_pend = 1'b0;
        end else begin
            if (busy_pend) chk("busy_after_valid", {31'd0, busy}, 32'd0);
            busy_pend = 1'b0;
            if (valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("data_out", {16'd0, data_out}, {16'd0, e.d});
                    chk("valid_cycle", cyc, e.c);
                end
                busy_pend = 1'b1;
            end else begin
                chk("data_out_hold", {16'd0, data_out}, {16'd0, prev_data});
            end
            prev_data = data_out;
        end
    end

    // Monitor for the corner instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid2) begin
            if (q2.size() == 0) begin
                chk("corner_unexpected_valid", {31'd0, valid2}, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("corner_data_out", {31'd0, data2}, {16'd0, e.d});
                chk("corner_valid_cycle", cyc, e.c);
            end
        end
    end

    // Drive one message. cmp corrupts the first and last 3 cycles of each bit;
    // pulse_at raises start during that message cycle; abort_at resets there.
    task automatic send(input logic [W-1:0] w, input bit cmp, input int pulse_at, input int abort_at);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        chk("busy_before_start", {31'd0, busy}, 32'd0);
        e.d = w;
        e.c = cyc + LAT;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        for (int k = 0; k < W; k++) begin
            for (int c = 0; c < BC; c++) begin
                int   n;
                logic b;
                n = 1 + k * BC + c;
                @(posedge clk); #1;
                b = w[W-1-k];
                if (cmp && (c < 3 || c >= BC - 3)) b = ~b;
                sin   = b;
                start = (n == pulse_at);
                if (n == abort_at) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("abort_data_out", {16'd0, data_out}, 32'd0);
                    chk("abort_valid", {31'd0, valid}, 32'd0);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    q.delete();
                    @(posedge clk); #1;
                    rst   = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        int   t;
        // reset values while held in reset
        #2;
        chk("reset_data_out", {16'd0, data_out}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // line activity without start must not wake the receiver
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            sin  = ~sin;
            sin2 = ~sin2;
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_busy2", {31'd0, busy2}, 32'd0);
        end
        sin  = 1'b0;
        sin2 = 1'b0;

        // asynchronous reset between edges
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_rst_data_out", {16'd0, data_out}, 32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // basic receive
        send(16'hA5C3, 1'b0, -1, -1);
        repeat (3) @(posedge clk);

        // mid-bit sampling with corrupted edges
        send(16'hA5C3, 1'b1, -1, -1);
        repeat (3) @(posedge clk);

        // back-to-back: next start in the cycle after valid
        send(16'hFFFF, 1'b0, -1, -1);
        @(posedge clk);
        send(16'h0001, 1'b0, -1, -1);
        repeat (3) @(posedge clk);

        // start mid-message is ignored
        send(16'h3C96, 1'b0, 40, -1);
        repeat (3) @(posedge clk);

        // reset mid-message: no valid, data_out cleared
        send(16'hBEEF, 1'b0, -1, 70);
        repeat (3 * BC) @(posedge clk);
        #1 chk("post_abort_data_out", {16'd0, data_out}, 32'd0);

        // recovery after abort
        send(16'h1234, 1'b0, -1, -1);
        repeat (3) @(posedge clk);

        // parameter corner: MSG_W=1, BIT_CYC=2
        @(posedge clk); #1;
        start2 = 1'b1;
        e.d = 16'd1;
        e.c = cyc + LAT2;
        q2.push_back(e);
        @(posedge clk); #1;
        start2 = 1'b0;
        sin2   = 1'b1;
        chk("corner_busy_rise", {31'd0, busy2}, 32'd1);

        // bounded wait for both scoreboards to drain
        t = 0;
        while ((q.size() + q2.size()) != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", q.size() + q2.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("corner_busy_fall", {31'd0, busy2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
